// File: rtl/poly_note_synth.sv
// Polyphonic PS/2 keyboard synthesizer: allocates note keys to VOICES square-wave
// voices and mixes them into a 1-bit speaker stream with a first-order sigma-delta.
module poly_note_synth #(
  parameter int VOICES = 4,
  parameter int CNT_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_valid,
  input  logic [7:0]            scan_byte,
  output logic                  speaker,
  output logic [VOICES-1:0]     voice_active,
  output logic [3*VOICES-1:0]   voice_note,
  output logic [VOICES-1:0]     voice_wave,
  output logic [1:0]            octave
);

  localparam int MIX_W = $clog2(VOICES + 1);
  localparam int ACC_W = $clog2(VOICES) + 1;
  localparam int PTR_W = $clog2(VOICES);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} parse_t;

  parse_t           state;
  logic [CNT_W-1:0] cnt   [VOICES];
  logic [CNT_W-1:0] limit [VOICES];
  logic [PTR_W-1:0] steal_ptr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_n;
  logic [MIX_W-1:0] mix;

  logic              make_evt, brk_evt, key_ok, free_found;
  logic [2:0]        key_note;
  logic [VOICES-1:0] held;
  logic [PTR_W-1:0]  free_idx, alloc_idx;

  // Returns {valid, note index} for the eight mapped note keys.
  function automatic logic [3:0] key_lookup(input logic [7:0] code);
    case (code)
      8'h1C:   return 4'b1_000;
      8'h1B:   return 4'b1_001;
      8'h23:   return 4'b1_010;
      8'h2B:   return 4'b1_011;
      8'h34:   return 4'b1_100;
      8'h33:   return 4'b1_101;
      8'h3B:   return 4'b1_110;
      8'h42:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] half_period(input logic [2:0] note);
    case (note)
      3'd0:    return CNT_W'(191109);
      3'd1:    return CNT_W'(170265);
      3'd2:    return CNT_W'(151685);
      3'd3:    return CNT_W'(143172);
      3'd4:    return CNT_W'(127550);
      3'd5:    return CNT_W'(113636);
      3'd6:    return CNT_W'(101238);
      default: return CNT_W'(95556);
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    {key_ok, key_note} = key_lookup(scan_byte);
    make_evt   = scan_valid && (state == IDLE) && (scan_byte != 8'hF0) && (scan_byte != 8'hE0);
    brk_evt    = scan_valid && (state == BRK);
    held       = '0;
    free_found = 1'b0;
    free_idx   = '0;
    mix        = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      held[v] = voice_active[v] && (voice_note[3*v +: 3] == key_note);
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(v);
      end
      mix = mix + MIX_W'(voice_wave[v]);
      case (octave)
        2'd0:    limit[v] = half_period(voice_note[3*v +: 3]) << 1;
        2'd1:    limit[v] = half_period(voice_note[3*v +: 3]);
        default: limit[v] = half_period(voice_note[3*v +: 3]) >> 1;
      endcase
    end
    alloc_idx = free_found ? free_idx : steal_ptr;
    acc_n     = acc + ACC_W'(mix);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset with everything else.
      state        <= IDLE;
      voice_active <= '0;
      voice_note   <= '0;
      voice_wave   <= '0;
      steal_ptr    <= '0;
      acc          <= '0;
      speaker      <= 1'b0;
      octave       <= 2'd1;
      for (int v = 0; v < VOICES; v++) cnt[v] <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (voice_active[v]) begin
          if (cnt[v] >= limit[v] - CNT_W'(1)) begin
            voice_wave[v] <= ~voice_wave[v];
            cnt[v]        <= '0;
          end else begin
            cnt[v] <= cnt[v] + CNT_W'(1);
          end
        end
      end

      if (scan_valid) begin
        case (state)
          IDLE:    state <= (scan_byte == 8'hF0) ? BRK : (scan_byte == 8'hE0) ? EXT : IDLE;
          EXT:     state <= (scan_byte == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end

      // NOTE: non-blocking writes below deliberately override the free-running update above; last one wins.
      if (make_evt && key_ok && (held == '0)) begin
        voice_active[alloc_idx]          <= 1'b1;
        voice_note[3*alloc_idx +: 3]     <= key_note;
        voice_wave[alloc_idx]            <= 1'b0;
        cnt[alloc_idx]                   <= '0;
        if (!free_found)
          steal_ptr <= (steal_ptr == PTR_W'(VOICES - 1)) ? '0 : steal_ptr + PTR_W'(1);
      end
      if (make_evt && (scan_byte == 8'h4E) && (octave != 2'd0)) octave <= octave - 2'd1;
      if (make_evt && (scan_byte == 8'h55) && (octave != 2'd2)) octave <= octave + 2'd1;

      if (brk_evt && key_ok) begin
        for (int v = 0; v < VOICES; v++) begin
          if (held[v]) begin
            voice_active[v] <= 1'b0;
            voice_wave[v]   <= 1'b0;
            cnt[v]          <= '0;
          end
        end
      end

      if (acc_n >= ACC_W'(VOICES)) begin
        speaker <= 1'b1;
        acc     <= acc_n - ACC_W'(VOICES);
      end else begin
        speaker <= 1'b0;
        acc     <= acc_n;
      end
    end
  end

endmodule

// File: tb/tb_poly_note_synth.sv
// Self-checking bench for poly_note_synth: directed scenarios plus random scancode
// traffic, compared every cycle against a behavioural model of the voice allocator.
module tb_poly_note_synth;

  localparam int VOICES = 4;
  localparam int TBL [8] = '{191109, 170265, 151685, 143172, 127550, 113636, 101238, 95556};
  localparam logic [7:0] CODES [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                scan_valid = 1'b0;
  logic [7:0]          scan_byte = 8'h00;
  logic                speaker;
  logic [VOICES-1:0]   voice_active;
  logic [3*VOICES-1:0] voice_note;
  logic [VOICES-1:0]   voice_wave;
  logic [1:0]          octave;

  poly_note_synth #(.VOICES(VOICES), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .speaker(speaker), .voice_active(voice_active), .voice_note(voice_note),
    .voice_wave(voice_wave), .octave(octave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cycle = 0;

  // Behavioural model state
  bit m_active [VOICES];
  int m_note   [VOICES];
  bit m_wave   [VOICES];
  int m_elapsed[VOICES];
  int m_ptr, m_oct, m_acc;
  bit m_spk, brk_pending, ext_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cycle, got, want);
    end
  endtask

  function automatic int key_idx(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (CODES[i] == b) return i;
    return -1;
  endfunction

  function automatic int lim(input int note, input int oct);
    if (oct == 0) return TBL[note] * 2;
    if (oct == 1) return TBL[note];
    return TBL[note] / 2;
  endfunction

  function automatic logic [31:0] dut_vec();
    return {9'd0, speaker, voice_active, voice_note, voice_wave, octave};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] r;
    r = '0;
    r[22] = m_spk;
    for (int i = 0; i < VOICES; i++) begin
      r[18+i]      = m_active[i];
      r[6+3*i +: 3] = 3'(m_note[i]);
      r[2+i]       = m_wave[i];
    end
    r[1:0] = 2'(m_oct);
    return r;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] b);
    int  mix, an, k, slot;
    bit  mk, bk, dup;
    if (r) begin
      for (int i = 0; i < VOICES; i++) begin
        m_active[i] = 0; m_note[i] = 0; m_wave[i] = 0; m_elapsed[i] = 0;
      end
      m_ptr = 0; m_oct = 1; m_acc = 0; m_spk = 0; brk_pending = 0; ext_pending = 0;
    end else begin
      mix = 0;
      for (int i = 0; i < VOICES; i++) mix += int'(m_wave[i]);
      an = m_acc + mix;
      m_spk = (an >= VOICES);
      m_acc = m_spk ? an - VOICES : an;
      for (int i = 0; i < VOICES; i++) begin
        if (m_active[i]) begin
          m_elapsed[i]++;
          if (m_elapsed[i] >= lim(m_note[i], m_oct)) begin
            m_wave[i] = !m_wave[i];
            m_elapsed[i] = 0;
          end
        end
      end
      mk = 0; bk = 0;
      if (v) begin
        if (b == 8'hF0 && !brk_pending) brk_pending = 1;
        else if (b == 8'hE0 && !brk_pending && !ext_pending) ext_pending = 1;
        else begin
          mk = !ext_pending && !brk_pending;
          bk = !ext_pending && brk_pending;
          brk_pending = 0; ext_pending = 0;
        end
      end
      k = key_idx(b);
      if (mk && k >= 0) begin
        dup = 0;
        for (int i = 0; i < VOICES; i++) if (m_active[i] && m_note[i] == k) dup = 1;
        if (!dup) begin
          slot = -1;
          for (int i = VOICES - 1; i >= 0; i--) if (!m_active[i]) slot = i;
          if (slot < 0) begin
            slot = m_ptr;
            m_ptr = (m_ptr + 1) % VOICES;
          end
          m_active[slot] = 1; m_note[slot] = k; m_wave[slot] = 0; m_elapsed[slot] = 0;
        end
      end
      if (mk && b == 8'h4E && m_oct > 0) m_oct--;
      if (mk && b == 8'h55 && m_oct < 2) m_oct++;
      if (bk && k >= 0)
        for (int i = 0; i < VOICES; i++)
          if (m_active[i] && m_note[i] == k) begin
            m_active[i] = 0; m_wave[i] = 0; m_elapsed[i] = 0;
          end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b);
    rst = r; scan_valid = v; scan_byte = b;
    model_step(r, v, b);
    @(posedge clk);
    #1;
    cycle++;
    check("cycle", dut_vec(), exp_vec());
  endtask

  task automatic key(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  initial begin
    int alloc_cyc [VOICES];
    int rise_cyc  [VOICES];
    int exp_rise  [VOICES];
    logic [7:0] rb;
    int sel;

    repeat (3) step(1'b1, 1'b0, 8'h00);
    check("reset_state", dut_vec(), 32'h1);

    key(8'h1C); key(8'h23); key(8'h34); key(8'h1C);
    check("alloc_active", 32'(voice_active), 32'h7);
    check("alloc_notes", 32'(voice_note), 32'h110);
    key(8'hF0); key(8'h23);
    check("release_active", 32'(voice_active), 32'h5);
    key(8'h2B);
    check("reuse_notes", 32'(voice_note), 32'h118);
    check("reuse_active", 32'(voice_active), 32'h7);

    key(8'hE0); key(8'h1C); key(8'hE0); key(8'hF0); key(8'h1C);
    key(8'hF0); key(8'h42);
    check("ext_ignored", 32'({voice_active, voice_note}), 32'h7118);
    key(8'h00);
    check("unmapped_make", 32'(voice_active), 32'h7);

    key(8'h33); key(8'h3B); key(8'h42);
    check("steal_two", 32'(voice_note), 32'hB3E);
    key(8'h1B);
    check("steal_ptr_2", 32'(voice_note), 32'hA7E);

    key(8'h55);
    check("octave_up", 32'(octave), 32'd2);
    key(8'h55);
    check("octave_sat_hi", 32'(octave), 32'd2);
    key(8'h4E); key(8'h4E); key(8'h4E); key(8'h4E);
    check("octave_sat_lo", 32'(octave), 32'd0);
    key(8'hF0); key(8'h55);
    check("break_octave_key", 32'(octave), 32'd0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 15);
      if (sel < 8)        rb = CODES[sel];
      else if (sel == 8)  rb = 8'hF0;
      else if (sel == 9)  rb = 8'hE0;
      else if (sel == 10) rb = 8'h4E;
      else if (sel == 11) rb = 8'h55;
      else                rb = 8'($urandom_range(0, 255));
      step(1'b0, ($urandom_range(0, 3) != 0), rb);
    end

    step(1'b1, 1'b0, 8'h00);
    check("reset_after_random", dut_vec(), 32'h1);

    // Four voices at the top octave so every first rising edge fits in the run.
    key(8'h55);
    key(8'h42); alloc_cyc[0] = cycle;
    key(8'h3B); alloc_cyc[1] = cycle;
    key(8'h33); alloc_cyc[2] = cycle;
    key(8'h34); alloc_cyc[3] = cycle;
    exp_rise = '{47778, 50619, 56818, 63775};
    rise_cyc = '{-1, -1, -1, -1};
    for (int n = 0; n < 63815; n++) begin
      step(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < VOICES; k++)
        if (rise_cyc[k] < 0 && voice_wave[k]) rise_cyc[k] = cycle;
    end
    for (int k = 0; k < VOICES; k++)
      check($sformatf("first_rise_v%0d", k), 32'(rise_cyc[k] - alloc_cyc[k]), 32'(exp_rise[k]));

    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b0, 8'h00);
      check("speaker_all_high", 32'(speaker), 32'd1);
    end

    step(1'b1, 1'b0, 8'h00);
    check("reset_mid_note", dut_vec(), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
